// File: rtl/conv_frame_sequencer_if.sv
// rtl/conv_frame_sequencer_if.sv - pixel memory and line buffer bus of the frame sequencer
interface conv_frame_sequencer_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 12
);
    logic                  mem_rd_en;
    logic [ADDR_WIDTH-1:0] mem_rd_addr;
    logic [DATA_WIDTH-1:0] mem_rd_data;
    logic                  lb_rst_n;
    logic [DATA_WIDTH-1:0] lb_data;
    logic                  lb_valid;
    logic                  lb_window_valid;

    modport master (
        output mem_rd_en, mem_rd_addr, lb_rst_n, lb_data, lb_valid,
        input  mem_rd_data, lb_window_valid
    );

    modport slave (
        input  mem_rd_en, mem_rd_addr, lb_rst_n, lb_data, lb_valid,
        output mem_rd_data, lb_window_valid
    );
endinterface

// File: rtl/conv_frame_sequencer.sv
// rtl/conv_frame_sequencer.sv - frame controller streaming pixels and flush zeros into a 3x3 line buffer
module conv_frame_sequencer #(
    parameter int DATA_WIDTH = 8,
    parameter int IMG_WIDTH  = 64,
    parameter int IMG_HEIGHT = 64,
    parameter int ADDR_WIDTH = $clog2(IMG_WIDTH*IMG_HEIGHT)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic                  feed_en,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH:0]   win_count,
    conv_frame_sequencer_if.master bus
);
    localparam int NPIX    = IMG_WIDTH * IMG_HEIGHT;
    localparam int FLUSH_N = IMG_WIDTH + 1;
    localparam int FCW     = $clog2(FLUSH_N + 1);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = ADDR_WIDTH'(NPIX - 1);
    localparam logic [ADDR_WIDTH:0]   WIN_MAX    = (ADDR_WIDTH+1)'(NPIX);
    localparam logic [FCW-1:0]        FLUSH_LAST = FCW'(FLUSH_N - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CLEAR = 3'd1;
    localparam logic [2:0] S_FILL  = 3'd2;
    localparam logic [2:0] S_FLUSH = 3'd3;
    localparam logic [2:0] S_DRAIN = 3'd4;

    logic [2:0]            state_q,      state_d;
    logic [ADDR_WIDTH-1:0] addr_q,       addr_d;
    logic [FCW-1:0]        flush_cnt_q,  flush_cnt_d;
    logic [ADDR_WIDTH:0]   win_count_q,  win_count_d;
    logic                  done_q,       done_d;
    logic                  lb_valid_q,   lb_valid_d;
    logic                  flush_flag_q, flush_flag_d;
    logic                  lb_rst_n_q,   lb_rst_n_d;
    logic                  issue;

    // Next-state, address/flush counters, window counting and the issue decision
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        flush_cnt_d = flush_cnt_q;
        win_count_d = win_count_q;
        done_d      = 1'b0;
        issue       = 1'b0;

        // Windows only count while a frame is in flight; the count saturates.
        if (state_q != S_IDLE && bus.lb_window_valid && win_count_q != WIN_MAX) begin
            win_count_d = win_count_q + (ADDR_WIDTH+1)'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    state_d     = S_CLEAR;
                    addr_d      = '0;
                    flush_cnt_d = '0;
                    win_count_d = '0;
                end
            end
            S_CLEAR: begin
                state_d = S_FILL;
            end
            S_FILL: begin
                if (feed_en) begin
                    issue = 1'b1;
                    // Hold the last address rather than wrapping past the frame.
                    if (addr_q == LAST_ADDR) begin
                        state_d = S_FLUSH;
                    end else begin
                        addr_d = addr_q + ADDR_WIDTH'(1);
                    end
                end
            end
            S_FLUSH: begin
                if (feed_en) begin
                    issue       = 1'b1;
                    flush_cnt_d = flush_cnt_q + FCW'(1);
                    if (flush_cnt_q == FLUSH_LAST) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                // Use the updated count so done lands the cycle after the final strobe.
                if (win_count_d == WIN_MAX) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Abort overrides every transition and drops the pixel being issued.
        if (abort && state_q != S_IDLE) begin
            state_d = S_IDLE;
            issue   = 1'b0;
            done_d  = 1'b0;
        end

        lb_valid_d   = issue;
        flush_flag_d = issue && (state_q == S_FLUSH);
        lb_rst_n_d   = (state_d != S_CLEAR);
    end

    // State and pipeline registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            addr_q       <= '0;
            flush_cnt_q  <= '0;
            win_count_q  <= '0;
            done_q       <= 1'b0;
            lb_valid_q   <= 1'b0;
            flush_flag_q <= 1'b0;
            lb_rst_n_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            flush_cnt_q  <= flush_cnt_d;
            win_count_q  <= win_count_d;
            done_q       <= done_d;
            lb_valid_q   <= lb_valid_d;
            flush_flag_q <= flush_flag_d;
            lb_rst_n_q   <= lb_rst_n_d;
        end
    end

    // Output drive; lb_data muxes the memory return against the registered flush flag
    always_comb begin
        busy            = (state_q != S_IDLE);
        done            = done_q;
        win_count       = win_count_q;
        bus.mem_rd_en   = (state_q == S_FILL) && feed_en;
        bus.mem_rd_addr = addr_q;
        bus.lb_rst_n    = lb_rst_n_q;
        bus.lb_valid    = lb_valid_q;
        bus.lb_data     = flush_flag_q ? '0 : bus.mem_rd_data;
    end
endmodule

// File: tb/tb_conv_frame_sequencer.sv
// tb/tb_conv_frame_sequencer.sv - self-checking bench for conv_frame_sequencer
module tb_conv_frame_sequencer;
    localparam int DW   = 8;
    localparam int W    = 4;
    localparam int H    = 3;
    localparam int AW   = 4;
    localparam int NPIX = W * H;
    localparam int NISS = NPIX + W + 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic abort = 1'b0;
    logic feed_en = 1'b0;
    logic busy, done;
    logic [AW:0] win_count;

    conv_frame_sequencer_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    conv_frame_sequencer #(
        .DATA_WIDTH(DW), .IMG_WIDTH(W), .IMG_HEIGHT(H), .ADDR_WIDTH(AW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .feed_en(feed_en),
        .busy(busy), .done(done), .win_count(win_count), .bus(bus)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // pixel memory with one-cycle read latency
    logic [DW-1:0] mem [0:NPIX-1];
    initial for (int i = 0; i < NPIX; i++) mem[i] = DW'(8'hA0 + i);
    always @(posedge clk) if (bus.mem_rd_en) bus.mem_rd_data <= mem[bus.mem_rd_addr];

    // line buffer stand-in: a window follows each pixel from index W+1 onward
    int lb_cnt;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lb_cnt <= 0;
            bus.lb_window_valid <= 1'b0;
        end else if (!bus.lb_rst_n) begin
            lb_cnt <= 0;
            bus.lb_window_valid <= 1'b0;
        end else begin
            bus.lb_window_valid <= bus.lb_valid && lb_cnt >= W + 1 && lb_cnt <= NPIX + W;
            if (bus.lb_valid) lb_cnt <= lb_cnt + 1;
        end
    end

    // behavioural model: frame progress expressed as issue and window counts
    int cyc = 0;
    bit m_busy = 0, m_clear = 0, m_done = 0, m_pv = 0, m_lbrst = 0, m_now = 0;
    int m_iss = 0, m_wins = 0, m_pidx = 0;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy = 0; m_clear = 0; m_done = 0; m_pv = 0; m_lbrst = 0;
            m_iss = 0; m_wins = 0;
        end else begin
            cyc++;
            m_now  = m_busy && !m_clear && m_iss < NISS && feed_en && !abort;
            m_done = 0;
            if (!m_busy) begin
                if (start && !abort) begin
                    m_busy = 1; m_clear = 1; m_iss = 0; m_wins = 0;
                end
            end else begin
                if (bus.lb_window_valid && m_wins < NPIX) m_wins++;
                if (abort) begin
                    m_busy = 0; m_clear = 0;
                end else begin
                    m_clear = 0;
                    if (m_iss == NISS && m_wins == NPIX) begin
                        m_busy = 0; m_done = 1;
                    end
                    if (m_now) begin
                        m_pidx = m_iss; m_iss++;
                    end
                end
            end
            m_pv    = m_now;
            m_lbrst = !m_clear;
        end
    end

    // trace of the current frame for literal timing checks
    bit tr_on = 0;
    int start_cyc = 0;
    int rd_first, rd_last, rd_n, a0_n, lbv_first, lbv_last, lbv_n, lbv_bub;
    int z_first, z_n, win_first, win_last, win_n, done_n, done_rel, lrst_n, lrst_rel, bf;
    bit was_busy = 0, fe_last = 0;

    task automatic tr_clear();
        rd_first = -1; rd_last = -1; rd_n = 0; a0_n = 0;
        lbv_first = -1; lbv_last = -1; lbv_n = 0; lbv_bub = 0;
        z_first = -1; z_n = 0; win_first = -1; win_last = -1; win_n = 0;
        done_n = 0; done_rel = -1; lrst_n = 0; lrst_rel = -1; bf = -1; was_busy = 0;
    endtask

    // compare process
    bit exp_rd;
    int rel;
    always @(negedge clk) begin
        exp_rd = m_busy && !m_clear && m_iss < NPIX && feed_en;
        chk("busy", 32'(busy), 32'(m_busy));
        chk("done", 32'(done), 32'(m_done));
        chk("win_count", 32'(win_count), 32'(m_wins));
        chk("mem_rd_en", 32'(bus.mem_rd_en), 32'(exp_rd));
        chk("lb_valid", 32'(bus.lb_valid), 32'(m_pv));
        chk("lb_rst_n", 32'(bus.lb_rst_n), 32'(m_lbrst));
        if (exp_rd) chk("mem_rd_addr", 32'(bus.mem_rd_addr), 32'(m_iss));
        if (m_pv) chk("lb_data", 32'(bus.lb_data), 32'(m_pidx < NPIX ? mem[m_pidx] : 8'h00));
        if (!rst_n) chk("mem_rd_addr_rst", 32'(bus.mem_rd_addr), 32'd0);
        if (tr_on && rst_n) begin
            rel = cyc - start_cyc;
            if (bus.mem_rd_en) begin
                if (rd_first < 0) rd_first = rel;
                rd_last = rel; rd_n++;
                if (bus.mem_rd_addr == '0) a0_n++;
            end
            if (bus.lb_valid) begin
                if (lbv_first < 0) lbv_first = rel;
                lbv_last = rel; lbv_n++;
                if (!fe_last) lbv_bub++;
                if (bus.lb_data == '0) begin
                    z_n++;
                    if (z_first < 0) z_first = rel;
                end
            end
            if (bus.lb_window_valid) begin
                if (win_first < 0) win_first = rel;
                win_last = rel; win_n++;
            end
            if (done) begin done_n++; done_rel = rel; end
            if (!bus.lb_rst_n) begin
                lrst_n++;
                if (lrst_rel < 0) lrst_rel = rel;
            end
            if (!busy && was_busy && bf < 0) bf = rel;
            was_busy = busy;
        end
        fe_last = feed_en;
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic begin_frame();
        tr_clear();
        start_cyc = cyc;
        tr_on = 1;
        start = 1'b1;
    endtask

    task automatic wait_done(input int max, input bit tog, input bit keep_start);
        bit seen;
        seen = 0;
        for (int i = 0; i < max && !seen; i++) begin
            tick();
            if (!keep_start) start = 1'b0;
            if (tog) feed_en = ~feed_en;
            if (done) seen = 1;
        end
        chk("done_seen", 32'(seen), 32'd1);
    endtask

    initial begin
        tr_clear();
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        // start together with abort in IDLE is ignored
        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        tick();
        chk("idle_abort_busy", 32'(busy), 32'd0);

        // frame 1: continuous feed, pinned timing
        feed_en = 1'b1;
        begin_frame();
        wait_done(100, 0, 0);
        tick(); tick();
        chk("f1_lrst_rel", rd_first >= 0 ? lrst_rel : -1, 1);
        chk("f1_rd_first", rd_first, 2);
        chk("f1_rd_last", rd_last, 13);
        chk("f1_rd_n", rd_n, 12);
        chk("f1_lbv_first", lbv_first, 3);
        chk("f1_lbv_last", lbv_last, 19);
        chk("f1_lbv_n", lbv_n, 17);
        chk("f1_zero_first", z_first, 15);
        chk("f1_zero_n", z_n, 5);
        chk("f1_win_first", win_first, 9);
        chk("f1_win_last", win_last, 20);
        chk("f1_done_rel", done_rel, 21);
        chk("f1_busy_fall", bf, 21);
        chk("f1_win_count", 32'(win_count), 32'd12);

        // frame 2: feed_en toggling every cycle
        begin_frame();
        wait_done(200, 1, 0);
        feed_en = 1'b1;
        tick(); tick();
        chk("tog_lbv_n", lbv_n, 17);
        chk("tog_win_n", win_n, 12);
        chk("tog_done_n", done_n, 1);
        chk("tog_bubble_valid", lbv_bub, 0);

        // back-to-back frames
        begin_frame();
        wait_done(100, 0, 0);
        start = 1'b1;
        wait_done(100, 0, 0);
        tick(); tick();
        chk("b2b_done_n", done_n, 2);
        chk("b2b_lrst_n", lrst_n, 2);
        chk("b2b_addr0_n", a0_n, 2);
        chk("b2b_win_count", 32'(win_count), 32'd12);

        // abort while address 6 is being read
        begin_frame();
        tick();
        start = 1'b0;
        for (int i = 0; i < 50 && !(bus.mem_rd_en && bus.mem_rd_addr == AW'(6)); i++) tick();
        chk("abort_reached_addr6", 32'(bus.mem_rd_addr), 32'd6);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_rd_en", 32'(bus.mem_rd_en), 32'd0);
        tick();
        chk("abort_lb_valid", 32'(bus.lb_valid), 32'd0);
        repeat (10) tick();
        chk("abort_done_n", done_n, 0);
        chk("abort_win_count", 32'(win_count), 32'd0);
        begin_frame();
        wait_done(100, 0, 0);
        tick(); tick();
        chk("post_abort_win_n", win_n, 12);
        chk("post_abort_win_count", 32'(win_count), 32'd12);

        // start held through a whole frame
        begin_frame();
        wait_done(100, 0, 1);
        tick();
        start = 1'b0;
        wait_done(100, 0, 0);
        tick(); tick();
        chk("held_lrst_n", lrst_n, 2);
        chk("held_done_n", done_n, 2);

        // asynchronous reset in the middle of FLUSH
        begin_frame();
        tick();
        start = 1'b0;
        repeat (15) tick();
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_win_count", 32'(win_count), 32'd0);
        chk("rst_rd_en", 32'(bus.mem_rd_en), 32'd0);
        chk("rst_addr", 32'(bus.mem_rd_addr), 32'd0);
        chk("rst_lb_valid", 32'(bus.lb_valid), 32'd0);
        chk("rst_lb_rst_n", 32'(bus.lb_rst_n), 32'd0);
        tr_on = 0;
        tick(); tick();
        rst_n = 1'b1;
        tick();
        begin_frame();
        wait_done(100, 0, 0);
        tick(); tick();
        chk("post_rst_win_n", win_n, 12);
        chk("post_rst_done_n", done_n, 1);
        chk("post_rst_win_count", 32'(win_count), 32'd12);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
